// File: rtl/instr_encoder_if.sv
// Field-level instruction load bus between an instruction source and the encoder.
// Carries the valid/ready field handshake plus the encoder's memory-write and status outputs.
// master drives instruction fields and session control; slave (the encoder) drives the rest.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic              func1;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output start, base_addr, in_valid, in_last, fmt, opcode, func3, func1,
               rd, rs1, rs2, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, full,
               err, err_code
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, fmt, opcode, func3, func1,
               rd, rs1, rs2, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, full,
               err, err_code
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V style instruction fields into 32-bit words and writes them to sequential memory words.
// Latency: one cycle from field accept to mem_we/mem_addr/mem_wdata; one write per cycle sustained.
// Backpressure: in_ready is high only while loading and not full; rejected (erroneous) fields write nothing.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  wptr;
    logic               accept;
    logic               enc_ok;
    logic [31:0]        enc;
    logic [1:0]         ecode;
    logic signed [31:0] simm;

    assign bus.in_ready = (state == LOAD) && !bus.full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign simm         = bus.imm;
    assign enc_ok       = (ecode == 2'b00);

    // Pack the fields of the presented instruction according to its format
    always_comb begin
        enc = 32'h0;
        case (bus.fmt)
            3'd0: enc = {1'b0, bus.func1, 5'b00000, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
            3'd1: enc = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
            3'd2: enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3, bus.imm[4:0], bus.opcode};
            3'd3: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                         bus.imm[4:1], bus.imm[11], bus.opcode};
            3'd4: enc = {bus.imm[31:12], bus.rd, bus.opcode};
            3'd5: enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
            default: enc = 32'h0;
        endcase
    end

    // Classify the presented instruction; bad format beats misalignment beats range
    always_comb begin
        ecode = 2'b00;
        if (bus.fmt > 3'd5) begin
            ecode = 2'b01;
        end else if ((bus.fmt == 3'd3 || bus.fmt == 3'd5) && bus.imm[0]) begin
            ecode = 2'b10;
        end else begin
            case (bus.fmt)
                3'd1, 3'd2: if (simm < -32'sd2048 || simm > 32'sd2047) ecode = 2'b11;
                3'd3:       if (simm < -32'sd4096 || simm > 32'sd4094) ecode = 2'b11;
                3'd5:       if (simm < -32'sd1048576 || simm > 32'sd1048574) ecode = 2'b11;
                default:    ecode = 2'b00;
            endcase
        end
    end

    // Session state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Session sequencing: last instruction or a write into the final word ends the session
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: if (accept && (bus.in_last || (enc_ok && wptr == LAST_ADDR))) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer, memory write port and registered session status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'h0;
            bus.count     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.full      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= 2'b00;
        end else begin
            bus.mem_we <= 1'b0;
            bus.busy   <= (state_nxt != IDLE);
            bus.done   <= (state == LOAD) && (state_nxt == FIN);
            if (state == IDLE && bus.start) begin
                wptr         <= bus.base_addr;
                bus.count    <= '0;
                bus.full     <= 1'b0;
                bus.err      <= 1'b0;
                bus.err_code <= 2'b00;
            end
            if (accept) begin
                if (enc_ok) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= wptr;
                    bus.mem_wdata <= enc;
                    bus.count     <= bus.count + 1'b1;
                    // The pointer parks on the final word instead of wrapping
                    if (wptr == LAST_ADDR) bus.full <= 1'b1;
                    else                   wptr     <= wptr + 1'b1;
                end else begin
                    bus.err <= 1'b1;
                    if (!bus.err) bus.err_code <= ecode;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed examples, format boundaries, full/reset cases, random sessions.
// Uses a 10-bit address instance for most tests and a 2-bit instance for the full-memory case.
// Inputs change on the falling edge; outputs are compared on the falling edge after each accept.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) eb ();
    instr_encoder_if #(.ADDR_W(2))  sb ();

    instr_encoder #(.ADDR_W(10)) dut  (.clk(clk), .reset(reset), .bus(eb));
    instr_encoder #(.ADDR_W(2))  sdut (.clk(clk), .reset(reset), .bus(sb));

    // Reference encoding built from bit positions with shifts and masks
    function automatic logic [31:0] model_word(input logic [31:0] f, op, f3, f1, d, s1, s2, im);
        logic [31:0] w;
        w = op & 32'h7F;
        case (f)
            0: w |= (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (f1 << 30);
            1: w |= (d << 7) | (f3 << 12) | (s1 << 15) | ((im & 32'hFFF) << 20);
            2: w |= ((im & 32'h1F) << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20)
                    | (((im >> 5) & 32'h7F) << 25);
            3: w |= (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8) | (f3 << 12)
                    | (s1 << 15) | (s2 << 20) | (((im >> 5) & 32'h3F) << 25)
                    | (((im >> 12) & 32'h1) << 31);
            4: w |= (d << 7) | (im & 32'hFFFFF000);
            5: w |= (d << 7) | (im & 32'h000FF000) | (((im >> 11) & 32'h1) << 20)
                    | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Reference error classification on the signed immediate value
    function automatic logic [1:0] model_err(input logic [31:0] f, input logic [31:0] im);
        int v;
        v = $signed(im);
        if (f >= 6) return 2'b01;
        if ((f == 3 || f == 5) && im[0]) return 2'b10;
        if ((f == 1 || f == 2) && (v < -2048 || v > 2047)) return 2'b11;
        if (f == 3 && (v < -4096 || v > 4094)) return 2'b11;
        if (f == 5 && (v < -1048576 || v > 1048574)) return 2'b11;
        return 2'b00;
    endfunction

    task automatic put(input logic [31:0] f, op, f3, f1, d, s1, s2, im, input logic last);
        eb.in_valid = 1'b1; eb.in_last = last;
        eb.fmt = f[2:0]; eb.opcode = op[6:0]; eb.func3 = f3[2:0]; eb.func1 = f1[0];
        eb.rd = d[4:0]; eb.rs1 = s1[4:0]; eb.rs2 = s2[4:0]; eb.imm = im;
    endtask

    task automatic begin_session(input logic [9:0] base);
        eb.start = 1'b1; eb.base_addr = base;
        @(negedge clk);
        eb.start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (eb.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", eb.mem_we); end
        total++; if (eb.mem_addr !== 10'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", eb.mem_addr); end
        total++; if (eb.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", eb.mem_wdata); end
        total++; if (eb.count !== 11'h0) begin bad++; $display("FAIL rst_count got=%0d want=0", eb.count); end
        total++; if ({eb.busy, eb.done, eb.full, eb.err, eb.in_ready} !== 5'b0) begin
            bad++; $display("FAIL rst_flags got=%b want=00000", {eb.busy, eb.done, eb.full, eb.err, eb.in_ready}); end
        total++; if (eb.err_code !== 2'b00) begin bad++; $display("FAIL rst_code got=%b want=00", eb.err_code); end
        total++; if ({sb.busy, sb.full, sb.in_ready, sb.mem_we} !== 4'b0) begin
            bad++; $display("FAIL rst_small got=%b want=0000", {sb.busy, sb.full, sb.in_ready, sb.mem_we}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed_b2b;
        logic [31:0] addr_exp[4];
        logic [31:0] data_exp[4];
        addr_exp = '{32'h010, 32'h011, 32'h012, 32'h013};
        data_exp = '{32'h00500093, 32'h402081B3, 32'h0020A423, 32'hFE208EE3};
        begin_session(10'h010);
        total++; if (eb.busy !== 1'b1 || eb.in_ready !== 1'b1) begin
            bad++; $display("FAIL load_entry busy/rdy got=%b%b want=11", eb.busy, eb.in_ready); end
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: put(1, 7'b0010011, 0, 0, 1, 0, 0, 5, 1'b0);
                1: put(0, 7'b0110011, 0, 1, 3, 1, 2, 0, 1'b0);
                2: put(2, 7'b0100011, 3'b010, 0, 0, 1, 2, 8, 1'b0);
                default: put(3, 7'b1100011, 0, 0, 0, 1, 2, -4, 1'b1);
            endcase
            @(negedge clk);
            total++; if (eb.mem_we !== 1'b1 || eb.mem_addr !== addr_exp[k][9:0] || eb.mem_wdata !== data_exp[k]) begin
                bad++; $display("FAIL directed_write%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                                k, eb.mem_we, eb.mem_addr, eb.mem_wdata, addr_exp[k][9:0], data_exp[k]); end
            total++; if (eb.count !== 11'(k + 1)) begin bad++; $display("FAIL directed_count%0d got=%0d want=%0d", k, eb.count, k + 1); end
            total++; if (eb.done !== (k == 3)) begin bad++; $display("FAIL directed_done%0d got=%b want=%b", k, eb.done, k == 3); end
        end
        eb.in_valid = 1'b0;
        @(negedge clk);
        total++; if ({eb.done, eb.busy, eb.mem_we, eb.in_ready} !== 4'b0) begin
            bad++; $display("FAIL directed_end got=%b want=0000", {eb.done, eb.busy, eb.mem_we, eb.in_ready}); end
        total++; if (eb.count !== 11'd4) begin bad++; $display("FAIL directed_hold_count got=%0d want=4", eb.count); end
    endtask

    task automatic test_errors;
        begin_session(10'h100);
        total++; if (eb.err !== 1'b0 || eb.count !== 11'd0) begin
            bad++; $display("FAIL err_clear got err=%b cnt=%0d want 0 0", eb.err, eb.count); end
        put(1, 7'b0010011, 0, 0, 2, 0, 0, 1, 1'b0);
        @(negedge clk);
        total++; if (eb.mem_we !== 1'b1 || eb.count !== 11'd1) begin
            bad++; $display("FAIL err_pre_write got we=%b cnt=%0d want 1 1", eb.mem_we, eb.count); end
        put(5, 7'b1101111, 0, 0, 1, 0, 0, 3, 1'b0);
        @(negedge clk);
        total++; if (eb.mem_we !== 1'b0 || eb.err !== 1'b1 || eb.err_code !== 2'b10 || eb.count !== 11'd1) begin
            bad++; $display("FAIL err_misalign got we=%b err=%b code=%b cnt=%0d want 0 1 10 1",
                            eb.mem_we, eb.err, eb.err_code, eb.count); end
        put(1, 7'b0010011, 0, 0, 1, 0, 0, 4096, 1'b1);
        @(negedge clk);
        total++; if (eb.mem_we !== 1'b0 || eb.err_code !== 2'b10 || eb.count !== 11'd1 || eb.done !== 1'b1) begin
            bad++; $display("FAIL err_first_only got we=%b code=%b cnt=%0d done=%b want 0 10 1 1",
                            eb.mem_we, eb.err_code, eb.count, eb.done); end
        eb.in_valid = 1'b0;
        @(negedge clk);
        total++; if (eb.busy !== 1'b0 || eb.err !== 1'b1 || eb.err_code !== 2'b10) begin
            bad++; $display("FAIL err_hold got busy=%b err=%b code=%b want 0 1 10", eb.busy, eb.err, eb.err_code); end
    endtask

    task automatic test_boundaries;
        logic [31:0] bf[16];
        logic [31:0] bi[16];
        logic [1:0]  ec;
        logic [31:0] w;
        bf = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 5, 5, 5, 5, 6, 7, 4};
        bi = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 8193,
               1048574, 1048576, -1048576, -1048578, 3, 0, 32'hFFFFF123};
        for (int k = 0; k < 16; k++) begin
            begin_session(10'h200);
            put(bf[k], 7'h33, 5, 1, 7, 9, 11, bi[k], 1'b1);
            ec = model_err(bf[k], bi[k]);
            w = model_word(bf[k], 32'h33, 5, 1, 7, 9, 11, bi[k]);
            @(negedge clk);
            total++; if (eb.mem_we !== (ec == 2'b00) || eb.err_code !== ec || eb.done !== 1'b1) begin
                bad++; $display("FAIL bound%0d fmt=%0d imm=%0d got we=%b code=%b done=%b want we=%b code=%b done=1",
                                k, bf[k], $signed(bi[k]), eb.mem_we, eb.err_code, eb.done, ec == 2'b00, ec); end
            if (ec == 2'b00) begin
                total++; if (eb.mem_wdata !== w || eb.mem_addr !== 10'h200) begin
                    bad++; $display("FAIL bound%0d_data got a=%h d=%h want a=200 d=%h", k, eb.mem_addr, eb.mem_wdata, w); end
            end
            eb.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_full;
        logic [31:0] w;
        sb.start = 1'b1; sb.base_addr = 2'd2;
        @(negedge clk);
        sb.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb.in_valid = 1'b1; sb.in_last = 1'b0; sb.fmt = 3'd1; sb.opcode = 7'b0010011;
            sb.func3 = 3'd0; sb.func1 = 1'b0; sb.rd = 5'(k + 4); sb.rs1 = 5'd1; sb.rs2 = 5'd0; sb.imm = 32'(k + 1);
            w = model_word(1, 32'b0010011, 0, 0, 32'(k + 4), 1, 0, 32'(k + 1));
            @(negedge clk);
            if (k < 2) begin
                total++; if (sb.mem_we !== 1'b1 || sb.mem_addr !== 2'(k + 2) || sb.mem_wdata !== w) begin
                    bad++; $display("FAIL full_write%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                                    k, sb.mem_we, sb.mem_addr, sb.mem_wdata, k + 2, w); end
                total++; if (sb.full !== (k == 1) || sb.in_ready !== (k == 0) || sb.done !== (k == 1)) begin
                    bad++; $display("FAIL full_flags%0d got full=%b rdy=%b done=%b want %b %b %b",
                                    k, sb.full, sb.in_ready, sb.done, k == 1, k == 0, k == 1); end
            end else begin
                total++; if (sb.mem_we !== 1'b0 || sb.done !== 1'b0 || sb.busy !== 1'b0 || sb.in_ready !== 1'b0
                             || sb.count !== 3'd2 || sb.full !== 1'b1) begin
                    bad++; $display("FAIL full_third got we=%b done=%b busy=%b rdy=%b cnt=%0d full=%b want 0 0 0 0 2 1",
                                    sb.mem_we, sb.done, sb.busy, sb.in_ready, sb.count, sb.full); end
            end
        end
        sb.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        begin_session(10'h050);
        put(1, 7'b0010011, 0, 0, 1, 0, 0, 5, 1'b0);
        @(negedge clk);
        eb.in_valid = 1'b0;
        total++; if (eb.mem_we !== 1'b1) begin bad++; $display("FAIL midrst_pre got we=%b want=1", eb.mem_we); end
        reset = 1'b1;
        #1;
        total++; if ({eb.mem_we, eb.busy, eb.done, eb.full, eb.err, eb.in_ready} !== 6'b0 || eb.mem_addr !== 10'h0
                     || eb.mem_wdata !== 32'h0 || eb.count !== 11'h0 || eb.err_code !== 2'b00) begin
            bad++; $display("FAIL midrst_outputs got we=%b a=%h d=%h cnt=%0d flags=%b code=%b want all zero",
                            eb.mem_we, eb.mem_addr, eb.mem_wdata, eb.count,
                            {eb.busy, eb.done, eb.full, eb.err, eb.in_ready}, eb.err_code); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        begin_session(10'h060);
        put(1, 7'b0010011, 0, 0, 1, 0, 0, 5, 1'b1);
        @(negedge clk);
        total++; if (eb.mem_we !== 1'b1 || eb.mem_addr !== 10'h060 || eb.mem_wdata !== 32'h00500093 || eb.count !== 11'd1) begin
            bad++; $display("FAIL midrst_resume got we=%b a=%h d=%h cnt=%0d want 1 060 00500093 1",
                            eb.mem_we, eb.mem_addr, eb.mem_wdata, eb.count); end
        eb.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] f, op, f3, f1, d, s1, s2, im, w;
        logic [1:0]  ec, mcode;
        logic        merr;
        int          base, mptr, mcnt, n, i, r;
        bit          v;
        for (int s = 0; s < 40; s++) begin
            base = $urandom_range(0, 1000);
            begin_session(base[9:0]);
            mptr = base; mcnt = 0; merr = 1'b0; mcode = 2'b00;
            n = $urandom_range(1, 8);
            i = 0;
            while (i < n) begin
                v = ($urandom_range(0, 3) != 0);
                if (v) begin
                    f  = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                    op = $urandom_range(0, 127); f3 = $urandom_range(0, 7); f1 = $urandom_range(0, 1);
                    d  = $urandom_range(0, 31); s1 = $urandom_range(0, 31); s2 = $urandom_range(0, 31);
                    if ($urandom_range(0, 7) == 0) r = int'($urandom);
                    else case (f)
                        1, 2:    r = int'($urandom_range(0, 4095)) - 2048;
                        3:       r = (int'($urandom_range(0, 4095)) - 2048) * 2;
                        5:       r = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                        default: r = int'($urandom);
                    endcase
                    im = r;
                    put(f, op, f3, f1, d, s1, s2, im, i == n - 1);
                end else begin
                    eb.in_valid = 1'b0;
                end
                @(negedge clk);
                if (v) begin
                    ec = model_err(f, im);
                    if (ec == 2'b00) begin
                        w = model_word(f, op, f3, f1, d, s1, s2, im);
                        total++; if (eb.mem_we !== 1'b1 || eb.mem_addr !== mptr[9:0] || eb.mem_wdata !== w) begin
                            bad++; $display("FAIL rand_write s=%0d fmt=%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                                            s, f, eb.mem_we, eb.mem_addr, eb.mem_wdata, mptr[9:0], w); end
                        mptr++; mcnt++;
                    end else begin
                        total++; if (eb.mem_we !== 1'b0) begin
                            bad++; $display("FAIL rand_nowrite s=%0d fmt=%0d got we=%b want 0", s, f, eb.mem_we); end
                        if (!merr) mcode = ec;
                        merr = 1'b1;
                    end
                    total++; if (eb.count !== mcnt[10:0] || eb.err !== merr || eb.err_code !== mcode) begin
                        bad++; $display("FAIL rand_status s=%0d got cnt=%0d err=%b code=%b want %0d %b %b",
                                        s, eb.count, eb.err, eb.err_code, mcnt, merr, mcode); end
                    i++;
                end else begin
                    total++; if (eb.mem_we !== 1'b0) begin bad++; $display("FAIL rand_idle_we s=%0d got=%b want=0", s, eb.mem_we); end
                end
            end
            eb.in_valid = 1'b0;
            total++; if (eb.done !== 1'b1) begin bad++; $display("FAIL rand_done s=%0d got=%b want=1", s, eb.done); end
            @(negedge clk);
            total++; if (eb.busy !== 1'b0 || eb.done !== 1'b0) begin
                bad++; $display("FAIL rand_end s=%0d got busy=%b done=%b want 0 0", s, eb.busy, eb.done); end
        end
    endtask

    initial begin
        eb.start = 1'b0; eb.base_addr = '0; eb.in_valid = 1'b0; eb.in_last = 1'b0; eb.fmt = '0;
        eb.opcode = '0; eb.func3 = '0; eb.func1 = 1'b0; eb.rd = '0; eb.rs1 = '0; eb.rs2 = '0; eb.imm = '0;
        sb.start = 1'b0; sb.base_addr = '0; sb.in_valid = 1'b0; sb.in_last = 1'b0; sb.fmt = '0;
        sb.opcode = '0; sb.func3 = '0; sb.func1 = 1'b0; sb.rd = '0; sb.rs1 = '0; sb.rs2 = '0; sb.imm = '0;
        test_reset();
        test_directed_b2b();
        test_errors();
        test_boundaries();
        test_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
